// File: rtl/decode_fetch_arbiter_if.sv
// Request and decode-side bus between the fetch requesters and decode_fetch_arbiter.
// Flattened request buses carry requester 0 in the MSBs.
interface decode_fetch_arbiter_if #(
  parameter int unsigned addressWidth            = 64,
  parameter int unsigned instructionWidth        = 32,
  parameter int unsigned PidSize                 = 20,
  parameter int unsigned TidSize                 = 16,
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned numRequesters           = 4,
  parameter int unsigned grantPtrWidth           = 3
);

  logic [numRequesters-1:0]                  reqValid_i;
  logic [numRequesters-1:0]                  reqReady_o;
  logic [numRequesters*instructionWidth-1:0] reqInstruction_i;
  logic [numRequesters*addressWidth-1:0]     reqAddress_i;
  logic [numRequesters-1:0]                  reqIs64Bit_i;
  logic [numRequesters*PidSize-1:0]          reqPid_i;
  logic [numRequesters*TidSize-1:0]          reqTid_i;

  logic                               enable_o;
  logic [instructionWidth-1:0]        instruction_o;
  logic [addressWidth-1:0]            instructionAddress_o;
  logic                               is64Bit_o;
  logic [PidSize-1:0]                 instructionPid_o;
  logic [TidSize-1:0]                 instructionTid_o;
  logic [instructionCounterWidth-1:0] instructionMajId_o;
  logic [grantPtrWidth-1:0]           grantIdx_o;

  // Arbiter side.
  modport slave (
    input  reqValid_i, reqInstruction_i, reqAddress_i, reqIs64Bit_i, reqPid_i, reqTid_i,
    output reqReady_o, enable_o, instruction_o, instructionAddress_o, is64Bit_o,
           instructionPid_o, instructionTid_o, instructionMajId_o, grantIdx_o
  );

  // Requester / decode side.
  modport master (
    output reqValid_i, reqInstruction_i, reqAddress_i, reqIs64Bit_i, reqPid_i, reqTid_i,
    input  reqReady_o, enable_o, instruction_o, instructionAddress_o, is64Bit_o,
           instructionPid_o, instructionTid_o, instructionMajId_o, grantIdx_o
  );

endinterface

// File: rtl/decode_fetch_arbiter.sv
// Round-robin arbiter feeding one decode unit from several fetch requesters, stamping major IDs.
// Optional per-requester grant and stall-cycle counters: define ARB_PERF_COUNTERS_EN.
module decode_fetch_arbiter #(
  parameter int unsigned addressWidth            = 64,
  parameter int unsigned instructionWidth        = 32,
  parameter int unsigned PidSize                 = 20,
  parameter int unsigned TidSize                 = 16,
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned numRequesters           = 4,
  parameter int unsigned grantPtrWidth           = 3
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic                 stall_i,
  decode_fetch_arbiter_if.slave bus
`ifdef ARB_PERF_COUNTERS_EN
  ,
  output logic [numRequesters*32-1:0] grantCount_o,
  output logic [31:0]                 stallCycles_o
`endif
);

  localparam int unsigned IdxW = (numRequesters > 1) ? $clog2(numRequesters) : 1;
  localparam logic [grantPtrWidth-1:0] LastInit = grantPtrWidth'(numRequesters - 1);

  // Per-requester views of the flattened buses, indexed by requester number.
  logic                        req_valid [numRequesters];
  logic [instructionWidth-1:0] req_instr [numRequesters];
  logic [addressWidth-1:0]     req_addr  [numRequesters];
  logic                        req_is64  [numRequesters];
  logic [PidSize-1:0]          req_pid   [numRequesters];
  logic [TidSize-1:0]          req_tid   [numRequesters];

  for (genvar g = 0; g < numRequesters; g++) begin : g_unpack
    localparam int unsigned R = numRequesters - 1 - g;
    assign req_valid[g] = bus.reqValid_i[R];
    assign req_is64[g]  = bus.reqIs64Bit_i[R];
    assign req_instr[g] = bus.reqInstruction_i[R*instructionWidth +: instructionWidth];
    assign req_addr[g]  = bus.reqAddress_i[R*addressWidth +: addressWidth];
    assign req_pid[g]   = bus.reqPid_i[R*PidSize +: PidSize];
    assign req_tid[g]   = bus.reqTid_i[R*TidSize +: TidSize];
  end

  logic                               enable_q, enable_d;
  logic [instructionWidth-1:0]        instr_q, instr_d;
  logic [addressWidth-1:0]            addr_q, addr_d;
  logic                               is64_q, is64_d;
  logic [PidSize-1:0]                 pid_q, pid_d;
  logic [TidSize-1:0]                 tid_q, tid_d;
  logic [instructionCounterWidth-1:0] majid_q, majid_d;
  logic [grantPtrWidth-1:0]           idx_q, idx_d;
  logic [grantPtrWidth-1:0]           last_q, last_d;
  logic [instructionCounterWidth-1:0] cnt_q, cnt_d;

  logic                     accept_c;
  logic                     found_c;
  logic                     transfer_c;
  logic [grantPtrWidth-1:0] sel_c;
  logic [IdxW-1:0]          sel_idx_c;
  logic [numRequesters-1:0] ready_c;

  // Round-robin scan starting one past the last granted requester.
  always_comb begin
    int unsigned k;
    accept_c  = reset_i && !flush_i && (!enable_q || !stall_i);
    found_c   = 1'b0;
    sel_c     = '0;
    sel_idx_c = '0;
    ready_c   = '0;
    k         = 0;
    for (int unsigned i = 0; i < numRequesters; i++) begin
      k = (32'(last_q) + 32'd1 + i) % numRequesters;
      if (accept_c && !found_c && req_valid[IdxW'(k)]) begin
        found_c   = 1'b1;
        sel_c     = grantPtrWidth'(k);
        sel_idx_c = IdxW'(k);
        ready_c[IdxW'(numRequesters - 1 - k)] = 1'b1;
      end
    end
    transfer_c = accept_c && found_c;
  end

  // Output register: load on transfer, drop valid when idle or flushed, hold while stalled.
  always_comb begin
    enable_d = enable_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    is64_d   = is64_q;
    pid_d    = pid_q;
    tid_d    = tid_q;
    majid_d  = majid_q;
    idx_d    = idx_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      enable_d = 1'b0;
    end else if (accept_c) begin
      if (found_c) begin
        enable_d = 1'b1;
        instr_d  = req_instr[sel_idx_c];
        addr_d   = req_addr[sel_idx_c];
        is64_d   = req_is64[sel_idx_c];
        pid_d    = req_pid[sel_idx_c];
        tid_d    = req_tid[sel_idx_c];
        majid_d  = cnt_q;
        idx_d    = sel_c;
        last_d   = sel_c;
        cnt_d    = cnt_q + instructionCounterWidth'(1);
      end else begin
        enable_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      enable_q <= 1'b0;
      instr_q  <= '0;
      addr_q   <= '0;
      is64_q   <= 1'b0;
      pid_q    <= '0;
      tid_q    <= '0;
      majid_q  <= '0;
      idx_q    <= '0;
      last_q   <= LastInit;
      cnt_q    <= '0;
    end else begin
      enable_q <= enable_d;
      instr_q  <= instr_d;
      addr_q   <= addr_d;
      is64_q   <= is64_d;
      pid_q    <= pid_d;
      tid_q    <= tid_d;
      majid_q  <= majid_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.reqReady_o           = ready_c;
  assign bus.enable_o             = enable_q;
  assign bus.instruction_o        = instr_q;
  assign bus.instructionAddress_o = addr_q;
  assign bus.is64Bit_o            = is64_q;
  assign bus.instructionPid_o     = pid_q;
  assign bus.instructionTid_o     = tid_q;
  assign bus.instructionMajId_o   = majid_q;
  assign bus.grantIdx_o           = idx_q;

`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] gcnt_q [numRequesters];
  logic [31:0] gcnt_d [numRequesters];
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters; flush does not touch them.
  always_comb begin
    for (int unsigned i = 0; i < numRequesters; i++) begin
      gcnt_d[i] = gcnt_q[i];
    end
    stall_cnt_d = stall_cnt_q;
    if (transfer_c && (gcnt_q[sel_idx_c] != 32'hFFFF_FFFF)) begin
      gcnt_d[sel_idx_c] = gcnt_q[sel_idx_c] + 32'd1;
    end
    if (enable_q && stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      for (int unsigned i = 0; i < numRequesters; i++) begin
        gcnt_q[i] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < numRequesters; i++) begin
        gcnt_q[i] <= gcnt_d[i];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  for (genvar g = 0; g < numRequesters; g++) begin : g_perf_out
    localparam int unsigned R = numRequesters - 1 - g;
    assign grantCount_o[R*32 +: 32] = gcnt_q[g];
  end
  assign stallCycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_fetch_arbiter.sv
// Directed bench for decode_fetch_arbiter: vector table plus hand sequences for ID wrap and perf counters.
module tb_decode_fetch_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  logic stall;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  decode_fetch_arbiter_if bus_if ();

`ifdef ARB_PERF_COUNTERS_EN
  logic [127:0] grant_count;
  logic [31:0]  stall_cycles;
`endif

  decode_fetch_arbiter dut (
    .clock_i (clk),
    .reset_i (reset_n),
    .flush_i (flush),
    .stall_i (stall),
    .bus     (bus_if)
`ifdef ARB_PERF_COUNTERS_EN
    ,
    .grantCount_o  (grant_count),
    .stallCycles_o (stall_cycles)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        stall;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic        en;
    logic [2:0]  idx;
    logic [63:0] maj;
    logic        chk;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] f_instr(int k); return 32'h7C00_0000 | 32'(k); endfunction
  function automatic logic [63:0] f_addr(int k);  return 64'h0000_1000_0000_0000 + 64'(k) * 64'h40; endfunction
  function automatic logic [19:0] f_pid(int k);   return 20'hA0000 + 20'(k); endfunction
  function automatic logic [15:0] f_tid(int k);   return 16'h0B00 + 16'(k); endfunction
  function automatic logic        f_is64(int k);  return (k % 2) == 1; endfunction

  function automatic vec_t mk(logic r, logic f, logic s, logic [3:0] v, logic [3:0] rdy,
                              logic e, logic [2:0] i, logic [63:0] m, logic c);
    vec_t t;
    t.rst_n = r; t.flush = f; t.stall = s; t.valid = v; t.ready = rdy;
    t.en = e; t.idx = i; t.maj = m; t.chk = c;
    return t;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_fields(string tag, int k);
    check({tag, " instr"}, 64'(bus_if.instruction_o), 64'(f_instr(k)));
    check({tag, " addr"},  bus_if.instructionAddress_o, f_addr(k));
    check({tag, " is64"},  64'(bus_if.is64Bit_o), 64'(f_is64(k)));
    check({tag, " pid"},   64'(bus_if.instructionPid_o), 64'(f_pid(k)));
    check({tag, " tid"},   64'(bus_if.instructionTid_o), 64'(f_tid(k)));
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    stall   = 1'b0;
    bus_if.reqValid_i = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      bus_if.reqInstruction_i[(3-k)*32 +: 32] = f_instr(k);
      bus_if.reqAddress_i[(3-k)*64 +: 64]     = f_addr(k);
      bus_if.reqIs64Bit_i[3-k]                = f_is64(k);
      bus_if.reqPid_i[(3-k)*20 +: 20]         = f_pid(k);
      bus_if.reqTid_i[(3-k)*16 +: 16]         = f_tid(k);
    end

    // Reset with everyone valid, then plain round robin.
    vq.push_back(mk(0,0,0,4'b1111,4'b0000,0,3'd0,64'd0,1));
    vq.push_back(mk(0,0,0,4'b1111,4'b0000,0,3'd0,64'd0,1));
    vq.push_back(mk(1,0,0,4'b1111,4'b1000,1,3'd0,64'd0,1));
    vq.push_back(mk(1,0,0,4'b1111,4'b0100,1,3'd1,64'd1,1));
    vq.push_back(mk(1,0,0,4'b1111,4'b0010,1,3'd2,64'd2,1));
    vq.push_back(mk(1,0,0,4'b1111,4'b0001,1,3'd3,64'd3,1));
    vq.push_back(mk(1,0,0,4'b1111,4'b1000,1,3'd0,64'd4,1));
    vq.push_back(mk(1,0,0,4'b1111,4'b0100,1,3'd1,64'd5,1));
    vq.push_back(mk(1,0,0,4'b1111,4'b0010,1,3'd2,64'd6,1));
    vq.push_back(mk(1,0,0,4'b1111,4'b0001,1,3'd3,64'd7,1));
    // Idle: valid drops, fields hold.
    vq.push_back(mk(1,0,0,4'b0000,4'b0000,0,3'd3,64'd7,1));
    // Re-reset, only requester 2, stall bubble of 3 cycles.
    vq.push_back(mk(0,0,0,4'b0010,4'b0000,0,3'd0,64'd0,1));
    vq.push_back(mk(1,0,0,4'b0010,4'b0010,1,3'd2,64'd0,1));
    vq.push_back(mk(1,0,1,4'b0010,4'b0000,1,3'd2,64'd0,1));
    vq.push_back(mk(1,0,1,4'b0010,4'b0000,1,3'd2,64'd0,1));
    vq.push_back(mk(1,0,1,4'b0010,4'b0000,1,3'd2,64'd0,1));
    vq.push_back(mk(1,0,0,4'b0010,4'b0010,1,3'd2,64'd1,1));
    // Flush with requesters valid, then IDs continue without a gap.
    vq.push_back(mk(1,1,0,4'b1111,4'b0000,0,3'd0,64'd0,0));
    vq.push_back(mk(1,0,0,4'b1111,4'b0001,1,3'd3,64'd2,1));
    vq.push_back(mk(1,0,0,4'b1111,4'b1000,1,3'd0,64'd3,1));
    // Stall while the register is empty still accepts.
    vq.push_back(mk(1,0,0,4'b0000,4'b0000,0,3'd0,64'd3,1));
    vq.push_back(mk(1,0,1,4'b1111,4'b0100,1,3'd1,64'd4,1));
    vq.push_back(mk(1,0,1,4'b1111,4'b0000,1,3'd1,64'd4,1));
    vq.push_back(mk(1,0,0,4'b0100,4'b0100,1,3'd1,64'd5,1));

    for (int i = 0; i < vq.size(); i++) begin
      reset_n = vq[i].rst_n;
      flush   = vq[i].flush;
      stall   = vq[i].stall;
      bus_if.reqValid_i = vq[i].valid;
      #1;
      check($sformatf("v%0d ready", i), 64'(bus_if.reqReady_o), 64'(vq[i].ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d enable", i), 64'(bus_if.enable_o), 64'(vq[i].en));
      if (vq[i].chk) begin
        check($sformatf("v%0d grantIdx", i), 64'(bus_if.grantIdx_o), 64'(vq[i].idx));
        check($sformatf("v%0d majId", i), bus_if.instructionMajId_o, vq[i].maj);
        if (vq[i].en) check_fields($sformatf("v%0d", i), int'(vq[i].idx));
      end
      if (i == 0) begin
        check("reset instr", 64'(bus_if.instruction_o), 64'd0);
        check("reset addr", bus_if.instructionAddress_o, 64'd0);
        check("reset pid", 64'(bus_if.instructionPid_o), 64'd0);
      end
    end

    // Major ID wrap: preload the counter to all ones during an idle cycle.
    bus_if.reqValid_i = 4'b0000;
    force dut.cnt_q = {64{1'b1}};
    @(posedge clk);
    #1;
    release dut.cnt_q;
    bus_if.reqValid_i = 4'b1000;
    #1;
    check("wrap ready0", 64'(bus_if.reqReady_o), 64'(4'b1000));
    @(posedge clk);
    #1;
    check("wrap majId0", bus_if.instructionMajId_o, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap idx0", 64'(bus_if.grantIdx_o), 64'd0);
    @(posedge clk);
    #1;
    check("wrap majId1", bus_if.instructionMajId_o, 64'd0);
    check("wrap enable1", 64'(bus_if.enable_o), 64'd1);
    @(posedge clk);
    #1;
    check("wrap majId2", bus_if.instructionMajId_o, 64'd1);

`ifdef ARB_PERF_COUNTERS_EN
    // 5 transfers from requester 1 with a 3-cycle stall bubble in the middle.
    reset_n = 1'b0;
    bus_if.reqValid_i = 4'b0100;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("perf reset g1", 64'(grant_count[2*32 +: 32]), 64'd0);
    for (int c = 0; c < 8; c++) begin
      stall = (c >= 2 && c < 5);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    bus_if.reqValid_i = 4'b0000;
    @(posedge clk);
    #1;
    check("perf grantCount r1", 64'(grant_count[2*32 +: 32]), 64'd5);
    check("perf grantCount r0", 64'(grant_count[3*32 +: 32]), 64'd0);
    check("perf stallCycles", 64'(stall_cycles), 64'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_fetch_arbiter.md
Name: decode_fetch_arbiter

Overview:
Round-robin arbiter that shares the single decode unit between several fetch requesters, for example per-thread fetch queues.
- Selects one valid requester per cycle and stamps the instruction with a unique, monotonically increasing major ID.
- Holds the result in an output register that drives the decode unit's enable_i, instruction and ID inputs.
- Honours the decode stall and supports a pipeline flush.

Parameters:
- addressWidth, 64, instruction address width
- instructionWidth, 32, instruction width (fixed 4-byte POWER instructions)
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID counter width
- numRequesters, 4, number of fetch requesters (2..8)
- grantPtrWidth, 3, width of the round-robin pointer; must satisfy 2**grantPtrWidth >= numRequesters

Ports:
- clock_i  in  1  clock
- reset_i  in  1  reset; synchronous, active-low
- flush_i  in  1  discard the output register contents; no grant in this cycle
- stall_i  in  1  decode unit cannot accept
- reqValid_i  in  numRequesters  requester k has an instruction
- reqReady_o  out  numRequesters  one-hot grant; transfer on reqValid_i[k] & reqReady_o[k]
- reqInstruction_i  in  numRequesters*instructionWidth  flattened, requester 0 in the MSBs
- reqAddress_i  in  numRequesters*addressWidth  flattened
- reqIs64Bit_i  in  numRequesters  per-requester mode
- reqPid_i  in  numRequesters*PidSize  flattened
- reqTid_i  in  numRequesters*TidSize  flattened
- enable_o  out  1  output register valid; drives decode enable_i
- instruction_o  out  instructionWidth
- instructionAddress_o  out  addressWidth
- is64Bit_o  out  1
- instructionPid_o  out  PidSize
- instructionTid_o  out  TidSize
- instructionMajId_o  out  instructionCounterWidth
- grantIdx_o  out  grantPtrWidth  index of the requester held in the output register

Behaviour:
- Reset (reset_i==0 at a posedge):
  - all outputs are 0 and reqReady_o is 0.
  - The last-grant pointer is set to numRequesters-1, so requester 0 wins first.
  - The major ID counter is set to 0.
  - Reset overrides flush and any transfer in the same cycle.
- Accept condition: accept = !flush_i && (!enable_o || !stall_i).
- Grant (combinational):
  - When accept is true, scan requesters starting at lastGrant+1, wrapping modulo numRequesters.
  - The first k with reqValid_i[k] gets reqReady_o[k]=1; all other ready bits are 0.
  - If accept is false or no request is valid, reqReady_o is all 0.
  - reqReady_o does not depend on reqValid_i of the selected requester beyond the selection itself.
- Transfer (posedge, accept and a grant exists):
  - Load the output register with requester k's instruction, address, is64Bit, pid and tid.
  - Load majId_o with the current counter value and set grantIdx_o=k and enable_o=1.
  - Increment the counter by 1; it wraps from all-ones to 0.
  - Set lastGrant=k.
- No transfer cases:
  - accept true with no valid requester: enable_o goes to 0 and the data fields hold their old values.
  - stall_i=1 with enable_o=1: the whole output register holds unchanged (the stall bubble).
- flush_i=1: enable_o=0 next cycle and no grant is issued. The counter and lastGrant are unchanged, so IDs stay unique across the flush.
- Latency: 1 cycle from the transfer edge to enable_o.
- Throughput: one instruction per cycle while stall_i=0.
- Fairness: a continuously valid requester is granted within numRequesters consecutive transfers.
- Flattened bus slicing: requester k's instruction occupies bits [k*instructionWidth +: instructionWidth] in the codebase's big-endian [0:N-1] numbering. The other flattened buses use the same scheme.

Optional Feature:
ARB_PERF_COUNTERS_EN:
- Defined:
  - Adds output grantCount_o, width numRequesters*32, flattened with the same slicing as the request buses.
  - Holds one 32-bit saturating counter per requester, incremented on each of that requester's transfers and held at 0xFFFFFFFF once reached.
  - Adds output stallCycles_o, 32 bits, saturating; counts cycles with enable_o=1 and stall_i=1.
  - All counters reset to 0 and are unaffected by flush_i.
- Undefined: these ports and registers are absent. All other behaviour is identical.

Test Plan:
- Reset with all reqValid_i=1: hold reset_i=0 for 2 cycles, then release.
  - While reset_i=0: enable_o=0, reqReady_o=0.
  - First cycle after release: reqReady_o=4'b1000 (requester 0).
  - Following edge: enable_o=1, grantIdx_o=0, instructionMajId_o=0.
- All 4 requesters valid, stall_i=0 for 8 cycles: grantIdx_o sequence 0,1,2,3,0,1,2,3; majId sequence 0..7.
- Only requester 2 valid, stall_i=1 for 3 cycles after its first grant:
  - Output holds (majId 0) and reqReady_o stays 0 during the stall.
  - When stall_i drops, the next grant is requester 2 again with majId 1.
- flush_i=1 for one cycle while enable_o=1 and requesters are valid:
  - Next cycle enable_o=0 and no ready bit was raised.
  - The following grant's majId continues from the pre-flush value with no gap.
- Counter wrap: preload the counter to 64'hFFFF_FFFF_FFFF_FFFF via the bench force path, then do two transfers. IDs must be FFFF..FF then 0.
- With ARB_PERF_COUNTERS_EN: 5 transfers from requester 1 and 3 stall cycles → requester 1's slice of grantCount_o = 5 and stallCycles_o = 3.
